// File: rtl/div_req_tracker.sv
// In-order tracker of divider requests. It records each issued operand vector with a
// timestamp and presents the oldest one, with its age and sticky error flags, to the checker.
module div_req_tracker #(
  parameter int WIDTH   = 64,
  parameter int DEPTH   = 4,
  parameter int MAX_LAT = 80
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       req_valid_i,
  input  logic                       req_ready_i,
  input  logic [WIDTH-1:0]           req_data_i,
  input  logic                       rsp_valid_i,
  input  logic                       rsp_ready_i,
  output logic                       head_valid_o,
  output logic [WIDTH-1:0]           head_data_o,
  output logic [15:0]                head_age_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       err_spurious_o,
  output logic                       err_overflow_o,
  output logic                       err_timeout_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [15:0]   MAX_LAT_W = 16'(MAX_LAT);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [15:0]      ts_q   [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [15:0]      cyc_q;
  logic             err_spurious_q, err_spurious_d;
  logic             err_overflow_q, err_overflow_d;
  logic             err_timeout_q, err_timeout_d;

  logic push, pop, empty, full;
  logic push_ok, pop_ok;
  logic head_valid;
  logic [15:0] head_age;

  assign push  = req_valid_i & req_ready_i;
  assign pop   = rsp_valid_i & rsp_ready_i;
  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

  assign head_valid = ~empty;
  assign head_age   = head_valid ? (cyc_q - ts_q[rd_ptr_q]) : 16'd0;

  // A pop on a full FIFO frees the slot the same-cycle push lands in, so that push is legal.
  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    push_ok        = 1'b0;
    pop_ok         = 1'b0;
    err_spurious_d = err_spurious_q;
    err_overflow_d = err_overflow_q;
    err_timeout_d  = err_timeout_q | (head_valid & (head_age >= MAX_LAT_W));
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      pop_ok  = pop & ~empty;
      push_ok = push & (~full | pop_ok);
      if (pop & empty)
        err_spurious_d = 1'b1;
      if (push & full & ~pop)
        err_overflow_d = 1'b1;
      if (push_ok)
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_ok)
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      cyc_q          <= '0;
      err_spurious_q <= 1'b0;
      err_overflow_q <= 1'b0;
      err_timeout_q  <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      cyc_q          <= cyc_q + 16'd1;
      err_spurious_q <= err_spurious_d;
      err_overflow_q <= err_overflow_d;
      err_timeout_q  <= err_timeout_d;
    end
  end

  // Storage is cleared on reset only so head_data reads 0 rather than X before the first push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        ts_q[i]   <= '0;
      end
    end else if (push_ok) begin
      data_q[wr_ptr_q] <= req_data_i;
      ts_q[wr_ptr_q]   <= cyc_q;
    end
  end

  assign head_valid_o   = head_valid;
  assign head_data_o    = data_q[rd_ptr_q];
  assign head_age_o     = head_age;
  assign count_o        = count_q;
  assign err_spurious_o = err_spurious_q;
  assign err_overflow_o = err_overflow_q;
  assign err_timeout_o  = err_timeout_q;

endmodule

// File: tb/tb_div_req_tracker.sv
// Directed bench for div_req_tracker: ordering, age, wrap, error flags, flush and reset.
module tb_div_req_tracker;

  logic        clk;
  logic        rst_n;
  logic        flush_i;
  logic        req_valid_i;
  logic        req_ready_i;
  logic [63:0] req_data_i;
  logic        rsp_valid_i;
  logic        rsp_ready_i;
  logic        head_valid_o;
  logic [63:0] head_data_o;
  logic [15:0] head_age_o;
  logic [2:0]  count_o;
  logic        err_spurious_o;
  logic        err_overflow_o;
  logic        err_timeout_o;

  int total = 0;
  int bad   = 0;

  div_req_tracker #(.WIDTH(64), .DEPTH(4), .MAX_LAT(80)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush_i        (flush_i),
    .req_valid_i    (req_valid_i),
    .req_ready_i    (req_ready_i),
    .req_data_i     (req_data_i),
    .rsp_valid_i    (rsp_valid_i),
    .rsp_ready_i    (rsp_ready_i),
    .head_valid_o   (head_valid_o),
    .head_data_o    (head_data_o),
    .head_age_o     (head_age_o),
    .count_o        (count_o),
    .err_spurious_o (err_spurious_o),
    .err_overflow_o (err_overflow_o),
    .err_timeout_o  (err_timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic push, input logic [63:0] data,
                               input logic pop, input logic fl);
    req_valid_i = push;
    req_ready_i = push;
    req_data_i  = data;
    rsp_valid_i = pop;
    rsp_ready_i = pop;
    flush_i     = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state, counter is 0 at this point.
    checkOutput("rst_count", 64'(count_o), 64'd0);
    checkOutput("rst_head_valid", 64'(head_valid_o), 64'd0);
    checkOutput("rst_head_data", head_data_o, 64'd0);
    checkOutput("rst_head_age", 64'(head_age_o), 64'd0);
    checkOutput("rst_errs", 64'({err_spurious_o, err_overflow_o, err_timeout_o}), 64'd0);

    // Single op: push 0xA5 at cycle 2, pop at cycle 7.
    tick(); tick();
    applyStimulus(1'b1, 64'hA5, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b0);
    checkOutput("single_count1", 64'(count_o), 64'd1);
    checkOutput("single_valid", 64'(head_valid_o), 64'd1);
    checkOutput("single_age1", 64'(head_age_o), 64'd1);
    tick(); tick(); tick(); tick();
    applyStimulus(1'b0, 64'h0, 1'b1, 1'b0);
    checkOutput("single_pop_data", head_data_o, 64'hA5);
    checkOutput("single_pop_age", 64'(head_age_o), 64'd5);
    tick();
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b0);
    checkOutput("single_count0", 64'(count_o), 64'd0);
    checkOutput("single_empty_age", 64'(head_age_o), 64'd0);

    // Fill and wrap.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 64'(i), 1'b0, 1'b0);
      tick();
    end
    checkOutput("fill_count4", 64'(count_o), 64'd4);
    applyStimulus(1'b1, 64'd4, 1'b1, 1'b0);
    checkOutput("wrap_pop_data", head_data_o, 64'd0);
    tick();
    checkOutput("wrap_no_overflow", 64'(err_overflow_o), 64'd0);
    checkOutput("wrap_count4", 64'(count_o), 64'd4);
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b0, 64'h0, 1'b1, 1'b0);
      checkOutput("wrap_order", head_data_o, 64'(i));
      tick();
    end
    checkOutput("wrap_count0", 64'(count_o), 64'd0);

    // Overflow: push 9 while full, data dropped.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 64'(i), 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b1, 64'd9, 1'b0, 1'b0);
    tick();
    checkOutput("ovf_flag", 64'(err_overflow_o), 64'd1);
    checkOutput("ovf_count", 64'(count_o), 64'd4);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 64'h0, 1'b1, 1'b0);
      checkOutput("ovf_order", head_data_o, 64'(i));
      tick();
    end
    checkOutput("ovf_count0", 64'(count_o), 64'd0);
    checkOutput("ovf_no_spurious", 64'(err_spurious_o), 64'd0);

    // Spurious: pop on empty with a same-cycle push of 0x11.
    applyStimulus(1'b1, 64'h11, 1'b1, 1'b0);
    tick();
    checkOutput("spur_flag", 64'(err_spurious_o), 64'd1);
    checkOutput("spur_count", 64'(count_o), 64'd1);
    checkOutput("spur_head", head_data_o, 64'h11);
    applyStimulus(1'b0, 64'h0, 1'b1, 1'b0);
    tick();
    checkOutput("spur_count0", 64'(count_o), 64'd0);
    checkOutput("spur_sticky", 64'(err_spurious_o), 64'd1);

    // Timeout at MAX_LAT=80.
    applyStimulus(1'b1, 64'h5A, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b0);
    checkOutput("to_age1", 64'(head_age_o), 64'd1);
    repeat (78) tick();
    checkOutput("to_age79", 64'(head_age_o), 64'd79);
    checkOutput("to_flag_at79", 64'(err_timeout_o), 64'd0);
    tick();
    checkOutput("to_age80", 64'(head_age_o), 64'd80);
    checkOutput("to_flag_at80", 64'(err_timeout_o), 64'd0);
    tick();
    checkOutput("to_flag_at81", 64'(err_timeout_o), 64'd1);
    applyStimulus(1'b0, 64'h0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b0);
    checkOutput("to_sticky", 64'(err_timeout_o), 64'd1);
    checkOutput("to_count0", 64'(count_o), 64'd0);

    // Flush with 3 entries plus a same-cycle push and pop.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 64'(8'hC0 + i), 1'b0, 1'b0);
      tick();
    end
    checkOutput("fl_pre_count", 64'(count_o), 64'd3);
    applyStimulus(1'b1, 64'hDD, 1'b1, 1'b1);
    tick();
    checkOutput("fl_count", 64'(count_o), 64'd0);
    checkOutput("fl_valid", 64'(head_valid_o), 64'd0);
    checkOutput("fl_errs_kept", 64'({err_spurious_o, err_overflow_o, err_timeout_o}), 64'd7);
    applyStimulus(1'b1, 64'h77, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b0);
    checkOutput("fl_new_count", 64'(count_o), 64'd1);
    checkOutput("fl_new_data", head_data_o, 64'h77);
    checkOutput("fl_new_age", 64'(head_age_o), 64'd1);

    // Asynchronous reset mid-operation.
    applyStimulus(1'b1, 64'h55, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b0);
    checkOutput("mid_pre_count", 64'(count_o), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_count", 64'(count_o), 64'd0);
    checkOutput("mid_rst_valid", 64'(head_valid_o), 64'd0);
    checkOutput("mid_rst_errs", 64'({err_spurious_o, err_overflow_o, err_timeout_o}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checkOutput("mid_post_count", 64'(count_o), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
